// File: rtl/seq_demux4.sv
// seq_demux4: sequential 1-to-4 bit demultiplexer with manual and round-robin
// (auto) lane selection, auto-mode nibble framing and a rotating LED heartbeat.
//
// Input handshake: din is accepted on every rising edge where din_valid=1;
// there is no ready signal, so the block never stalls and every valid bit is
// consumed in the cycle it is presented.
module seq_demux4 #(
  parameter int DIV = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic [1:0]  s,
  input  logic        auto_mode,
  output logic [3:0]  a,
  output logic [3:0]  upd,
  output logic [1:0]  ptr,
  output logic [3:0]  frame,
  output logic        frame_valid,
  output logic [15:0] led
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic {MAN = 1'b0, AUTO = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sel;
  logic [3:0]    a_nxt, upd_nxt, frame_nxt;
  logic [1:0]    ptr_nxt;
  logic          fv_nxt;
  logic [CW-1:0] cnt;

  // Lane steering follows the registered state, so a write on a mode-change
  // edge is still handled by the old mode's rules.
  assign sel = (state == AUTO) ? ptr : s;

  // Next-state, lane write, framing and mode-change clears.
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    upd_nxt   = upd;
    ptr_nxt   = ptr;
    frame_nxt = frame;
    fv_nxt    = 1'b0;

    if (din_valid) begin
      a_nxt[sel]   = din;
      upd_nxt[sel] = 1'b1;
      if (state == AUTO) begin
        ptr_nxt = ptr + 2'd1;
        if (ptr == 2'd3) begin
          // Nibble complete: publish it and consume the written flags.
          frame_nxt = {din, a[2], a[1], a[0]};
          fv_nxt    = 1'b1;
          upd_nxt   = 4'b0000;
        end
      end
    end

    // Mode-change clears win over the write's own ptr/upd update.
    case (state)
      MAN: begin
        if (auto_mode) begin
          state_nxt = AUTO;
          ptr_nxt   = 2'd0;
          upd_nxt   = 4'b0000;
        end
      end
      AUTO: begin
        if (!auto_mode) begin
          state_nxt = MAN;
          ptr_nxt   = 2'd0;
        end
      end
      default: state_nxt = MAN;
    endcase
  end

  // Datapath and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MAN;
      a           <= 4'b0000;
      upd         <= 4'b0000;
      ptr         <= 2'd0;
      frame       <= 4'b0000;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      a           <= a_nxt;
      upd         <= upd_nxt;
      ptr         <= ptr_nxt;
      frame       <= frame_nxt;
      frame_valid <= fv_nxt;
    end
  end

  // Heartbeat: rotate the single hot LED bit whenever the divider is at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      led <= 16'h0001;
    end else begin
      cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
      if (cnt == '0) led <= {led[14:0], led[15]};
    end
  end

endmodule

// File: tb/tb_seq_demux4.sv
// tb_seq_demux4: directed bench for seq_demux4 with a per-cycle reference
// model plus hand-computed literal expectations.
module tb_seq_demux4;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst, din, din_valid, auto_mode;
  logic [1:0]  s;
  logic [3:0]  a, upd, frame;
  logic [1:0]  ptr;
  logic        frame_valid;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  // Reference model state.
  logic [3:0]  m_a, m_upd, m_frame;
  int          m_ptr;
  bit          m_auto;
  logic        m_fv;
  logic [15:0] m_led;
  int          rel_n;
  bit          chk_en = 1'b0;

  seq_demux4 #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .s(s),
    .auto_mode(auto_mode), .a(a), .upd(upd), .ptr(ptr), .frame(frame),
    .frame_valid(frame_valid), .led(led)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge, then compare all outputs 1 time unit later.
  always begin
    @(posedge clk);
    if (rst) begin
      m_a = 4'b0; m_upd = 4'b0; m_ptr = 0; m_frame = 4'b0; m_fv = 1'b0;
      m_auto = 1'b0; m_led = 16'h0001; rel_n = 0; chk_en = 1'b1;
    end else if (chk_en) begin
      int lane;
      rel_n++;
      m_led = 16'h0001 << (((rel_n - 1) / DIV + 1) % 16);
      m_fv = 1'b0;
      if (din_valid) begin
        lane = m_auto ? m_ptr : int'(s);
        m_a[lane] = din;
        m_upd[lane] = 1'b1;
        if (m_auto) begin
          if (m_ptr == 3) begin
            m_frame = m_a;
            m_fv = 1'b1;
            m_upd = 4'b0;
          end
          m_ptr = (m_ptr + 1) % 4;
        end
      end
      if (auto_mode && !m_auto) begin
        m_auto = 1'b1; m_ptr = 0; m_upd = 4'b0;
      end else if (!auto_mode && m_auto) begin
        m_auto = 1'b0; m_ptr = 0;
      end
    end
    #1;
    if (chk_en) begin
      pulses += int'(frame_valid);
      chk("m_a", 16'(a), 16'(m_a));
      chk("m_upd", 16'(upd), 16'(m_upd));
      chk("m_ptr", 16'(ptr), 16'(m_ptr));
      chk("m_frame", 16'(frame), 16'(m_frame));
      chk("m_fv", 16'(frame_valid), 16'(m_fv));
      chk("m_led", led, m_led);
    end
  end

  // Driver: present inputs at the falling edge, return after the compare.
  task automatic cyc(input logic r, input logic d, input logic dv,
                     input logic [1:0] sel, input logic am);
    @(negedge clk);
    rst = r; din = d; din_valid = dv; s = sel; auto_mode = am;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; s = 2'd0; auto_mode = 1'b0;

    // Reset hold with random data activity.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 1'b0);
    chk("rst_a", 16'(a), 16'h0);
    chk("rst_upd", 16'(upd), 16'h0);
    chk("rst_ptr", 16'(ptr), 16'h0);
    chk("rst_fv", 16'(frame_valid), 16'h0);
    chk("rst_led", led, 16'h0001);

    // Manual steering and mux loopback.
    cyc(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    chk("led_first", led, 16'h0002);
    chk("man_a1", 16'(a), 16'h4);
    chk("loop1", 16'(a[2]), 16'h1);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("loop2", 16'(a[0]), 16'h1);
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    chk("loop3", 16'(a[2]), 16'h0);
    chk("man_a", 16'(a), 16'h1);
    chk("man_upd", 16'(upd), 16'h5);

    // Auto frame 1,0,1,1.
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("auto_ptr0", 16'(ptr), 16'h0);
    chk("auto_upd0", 16'(upd), 16'h0);
    p0 = pulses;
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1); chk("auto_ptr1", 16'(ptr), 16'h1);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b1); chk("auto_ptr2", 16'(ptr), 16'h2);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1); chk("auto_ptr3", 16'(ptr), 16'h3);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    chk("auto_ptr4", 16'(ptr), 16'h0);
    chk("auto_frame", 16'(frame), 16'hD);
    chk("auto_fv", 16'(frame_valid), 16'h1);
    chk("auto_upd", 16'(upd), 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("auto_fv_off", 16'(frame_valid), 16'h0);
    chk("auto_pulses", 16'(pulses - p0), 16'h1);

    // Gaps: 1, idle x5, 1, 0, 0.
    p0 = pulses;
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    chk("gap_frame", 16'(frame), 16'h3);
    // Back-to-back nibble 1,1,1,1.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    chk("b2b_frame", 16'(frame), 16'hF);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("gap_pulses", 16'(pulses - p0), 16'h2);

    // Mode switch mid-frame with a simultaneous valid.
    p0 = pulses;
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("sw_ptr", 16'(ptr), 16'h0);
    chk("sw_a2", 16'(a[2]), 16'h1);
    // Re-enter auto, two bits, then reset mid-frame.
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
    chk("mrst_a", 16'(a), 16'h0);
    chk("mrst_upd", 16'(upd), 16'h0);
    chk("mrst_ptr", 16'(ptr), 16'h0);
    chk("mrst_frame", 16'(frame), 16'h0);
    chk("mrst_led", led, 16'h0001);
    chk("sw_pulses", 16'(pulses - p0), 16'h0);

    // LED rotation and wrap over 61 edges after reset release.
    for (int n = 1; n <= 61; n++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      if (n == 1)  chk("led_e1", led, 16'h0002);
      if (n == 5)  chk("led_e5", led, 16'h0004);
      if (n == 9)  chk("led_e9", led, 16'h0008);
      if (n == 57) chk("led_e57", led, 16'h8000);
      if (n == 61) chk("led_wrap", led, 16'h0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_demux4.md
Name: seq_demux4

Overview:
- Sequential 1-to-4 demultiplexer. It performs the inverse of the team's 4:1 bit mux: one input bit is steered into one of four registered output bits.
- Manual mode: the destination lane is taken from an external 2-bit select.
- Auto mode: a 2-bit round-robin pointer selects the lane. Each complete group of four bits is emitted as a frame with a one-cycle valid pulse.
- A rotating 16-bit LED heartbeat provides board-level activity indication.

Parameters:
- DIV, 5000000, LED rotate period in clk cycles. Legal range is 2 or more; benches override it to a small value.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit to steer
- din_valid  input  1  din is captured in this cycle
- s  input  2  manual lane select (0..3)
- auto_mode  input  1  1 = round-robin pointer selects the lane; 0 = s selects the lane
- a  output  4  registered lane bits; a[k] holds the last bit steered to lane k
- upd  output  4  sticky per-lane "written since clear" flags
- ptr  output  2  current round-robin pointer
- frame  output  4  last completed auto-mode nibble, with frame[k] = bit written to lane k
- frame_valid  output  1  one-cycle pulse: frame was updated
- led  output  16  rotating heartbeat

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything else. Reset values:
  - a=0, upd=0, ptr=0, frame=0, frame_valid=0
  - led=16'h0001, internal counter=0, state=MAN
- State machine (2 states):
  - MAN -> AUTO when auto_mode=1. On the transition edge: ptr<=0, upd<=0.
  - AUTO -> MAN when auto_mode=0. On the transition edge: ptr<=0; upd is kept.
  - Lane selection uses the state register, not raw auto_mode. The din_valid accepted on a transition edge is therefore handled with the pre-transition state's rules.
- MAN, din_valid=1: a[s]<=din, upd[s]<=1. Other lanes hold. ptr is unchanged. frame_valid=0.
- AUTO, din_valid=1:
  - a[ptr]<=din, upd[ptr]<=1, ptr<=ptr+1 modulo 4 (3 wraps to 0).
  - If ptr==3: frame<={din, a[2], a[1], a[0]} and frame_valid<=1 on the next cycle. In the same edge, upd<=0 (frame consumed, upd fully cleared).
  - On the next cycle a reflects all four writes.
- din_valid=0: a, upd, ptr and frame hold. frame_valid<=0.
- frame_valid is high for exactly one cycle per completed nibble. Back-to-back nibbles give one pulse every 4 valid cycles.
- Latency: a and frame are visible 1 cycle after the capturing edge. There is no backpressure; every valid bit is accepted.
- Loopback property: after a MAN write with select s, feeding the 4:1 bit mux with (a, s) returns din.
- Simultaneous mode change and din_valid:
  - The bit is steered by the old state's rules.
  - The transition clears (ptr and, for MAN->AUTO, upd) take priority over that write's ptr/upd update.
  - The data bit in a is still written.
- Reset mid-frame: the partial nibble is discarded and no frame_valid is produced.
- LED heartbeat:
  - Counter runs 0..DIV-1 and wraps to 0.
  - When the counter==0, led<={led[14:0], led[15]} (rotate left).
  - First rotation happens on the edge after reset release. Thereafter it repeats every DIV cycles.
  - Exactly one led bit is high at all times.
  - Independent of mode and data.

Test Plan:
- Reset hold: assert rst 3 cycles with random din/din_valid -> a=0, upd=0, ptr=0, frame_valid=0, led=16'h0001.
- Manual steer: auto_mode=0; write (s=2, din=1), then (s=0, din=1), then (s=2, din=0) -> a=4'b0001, upd=4'b0101. Mux(a, s) equals din after each write.
- Auto frame: auto_mode=1; 4 consecutive valids with din=1,0,1,1 -> ptr 0,1,2,3,0; frame=4'b1101; frame_valid high exactly 1 cycle; upd=0 after.
- Gaps and wrap: auto mode, bits 1,1 with din_valid low for 5 cycles between them, then 0,0 -> frame=4'b0011, a single pulse. A second back-to-back nibble 1,1,1,1 -> frame=4'hF, a second single pulse.
- Mode switch and reset mid-frame: 2 auto bits, then auto_mode=0 with a simultaneous valid -> ptr=0 and no frame_valid. Re-enter auto, write 2 bits, assert rst -> no frame_valid, all outputs at reset values.
- LED: DIV=4 -> led=0002 after the first edge following reset, then 0004, 0008, ... every 4 cycles; 8000 wraps to 0001.
